fp_addsub_pipe: RTL and testbench

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

---
 rtl/fp_pkg.sv | 28 ++
 rtl/fp_lzc.sv | 22 ++
 rtl/fp_addsub_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the floating-point add/subtract pipeline.
//   fp_class_e     operand class (ZERO, NORM, INF, NAN)
//   FLAG_*         bit positions inside the 4-bit flags vector
//                  {invalid, overflow, underflow, inexact}
//   canonical_nan  builds the quiet-NaN bit pattern for a given format
package fp_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // Sign 0, exponent all ones, only the mantissa MSB set.
  // Returned in 64 bits; callers slice the low 1+exp_w+man_w bits.
  function automatic logic [63:0] canonical_nan(input int exp_w, input int man_w);
    logic [63:0] exp_ones;
    exp_ones = (64'd1 << exp_w) - 64'd1;
    return (exp_ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter.
//   value  input  [WIDTH-1:0]            word to scan from the MSB
//   count  output [$clog2(WIDTH+1)-1:0]  number of zeros above the first one
//                                        (WIDTH when value is zero)
module fp_lzc #(
  parameter int WIDTH = 28
) (
  input  logic [WIDTH-1:0]             value,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  localparam int CW = $clog2(WIDTH + 1);

  // Scan upward so the highest set bit is the last one to write count.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage IEEE-style floating-point adder/subtractor.
//   S1 unpack/classify/swap/align, S2 magnitude add/sub, S3 normalise/round/pack.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (a, b, sub; sub=1 computes a-b)
//   out_valid / out_ready result handshake (result, flags)
//   flags                 {invalid, overflow, underflow, inexact}
// Build option: FP_ADDSUB_RNE_EN selects round-to-nearest-even; without it the
// block truncates and saturates overflow to the largest finite value.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int XW     = MAN_W + 4;          // hidden bit + mantissa + G/R/S
  localparam int SW     = MAN_W + 5;          // XW plus carry-out
  localparam int EW     = EXP_W + 2;          // exponent with sign and headroom
  localparam int SH_MAX = MAN_W + 3;
  localparam int CW     = $clog2(SW + 1);
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [63:0]      QNAN_FULL = canonical_nan(EXP_W, MAN_W);
  localparam logic [W-1:0]     QNAN      = QNAN_FULL[W-1:0];

  typedef struct packed {
    logic             is_nan;
    logic             is_inf;
    logic             inf_sign;
    logic             sign;
    logic             zero_sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [XW-1:0]    xm;
    logic [XW-1:0]    ym;
  } s1_t;

  typedef struct packed {
    logic             is_nan;
    logic             is_inf;
    logic             inf_sign;
    logic             sign;
    logic             zero_sign;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    sum;
  } s2_t;

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) return ZERO;
    if (e == EXP_ONES) return (f == '0) ? INF : NAN;
    return NORM;
  endfunction

  logic v1, v2, v3;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic [W-1:0] res_d;
  logic [3:0]   flags_d;

  assign in_ready  = !(out_valid && !out_ready);
  assign out_valid = v3;

  // ---------------- S1: unpack, classify, swap, align ----------------
  logic            sa, sb;
  fp_class_e       ca, cb;
  logic [W-2:0]    mag_a, mag_b, x_mag, y_mag;
  logic [MAN_W:0]  x_mant, y_mant;
  logic [EXP_W-1:0] diff, shift_amt;
  logic [2*XW-1:0] align_wide;

  assign sa = a[W-1];
  assign sb = b[W-1] ^ sub;
  assign ca = classify(a[W-2:MAN_W], a[MAN_W-1:0]);
  assign cb = classify(b[W-2:MAN_W], b[MAN_W-1:0]);
  // Subnormals collapse to zero so they never enter the datapath.
  assign mag_a = (ca == ZERO) ? '0 : a[W-2:0];
  assign mag_b = (cb == ZERO) ? '0 : b[W-2:0];
  assign x_mag = (mag_a >= mag_b) ? mag_a : mag_b;
  assign y_mag = (mag_a >= mag_b) ? mag_b : mag_a;
  assign x_mant = (x_mag[W-2:MAN_W] == '0) ? '0 : {1'b1, x_mag[MAN_W-1:0]};
  assign y_mant = (y_mag[W-2:MAN_W] == '0) ? '0 : {1'b1, y_mag[MAN_W-1:0]};
  assign diff = x_mag[W-2:MAN_W] - y_mag[W-2:MAN_W];
  assign shift_amt = (diff > EXP_W'(SH_MAX)) ? EXP_W'(SH_MAX) : diff;
  // Lower half catches everything shifted past the sticky position.
  assign align_wide = {y_mant, 3'b000, {XW{1'b0}}} >> shift_amt;

  always_comb begin
    s1_d           = '0;
    s1_d.is_nan    = (ca == NAN) || (cb == NAN) || (ca == INF && cb == INF && sa != sb);
    s1_d.is_inf    = (ca == INF) || (cb == INF);
    s1_d.inf_sign  = (ca == INF) ? sa : sb;
    s1_d.zero_sign = (ca == ZERO) && (cb == ZERO) && sa && sb;
    s1_d.eff_sub   = sa ^ sb;
    s1_d.sign      = (mag_a >= mag_b) ? sa : sb;
    s1_d.exp       = x_mag[W-2:MAN_W];
    s1_d.xm        = {x_mant, 3'b000};
    s1_d.ym        = {align_wide[2*XW-1:XW+1], align_wide[XW] | (|align_wide[XW-1:0])};
  end

  // ---------------- S2: magnitude add / subtract ----------------
  always_comb begin
    s2_d           = '0;
    s2_d.is_nan    = s1_q.is_nan;
    s2_d.is_inf    = s1_q.is_inf;
    s2_d.inf_sign  = s1_q.inf_sign;
    s2_d.sign      = s1_q.sign;
    s2_d.zero_sign = s1_q.zero_sign;
    s2_d.exp       = s1_q.exp;
    s2_d.sum       = s1_q.eff_sub ? ({1'b0, s1_q.xm} - {1'b0, s1_q.ym})
                                  : ({1'b0, s1_q.xm} + {1'b0, s1_q.ym});
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [CW-1:0]    lz;
  logic [SW-1:0]    norm;
  logic [EW-1:0]    exp_n, exp_r;
  logic [MAN_W-1:0] mant, mant_r;
  logic             guard, rnd, stk, round_up, mant_carry, inexact;

  fp_lzc #(.WIDTH(SW)) u_lzc (
    .value (s2_q.sum),
    .count (lz)
  );

  // Leading one lands in the MSB; a zero sum shifts out completely.
  assign norm    = s2_q.sum << lz;
  assign exp_n   = {2'b00, s2_q.exp} + EW'(1) - EW'(lz);
  assign mant    = norm[SW-2:4];
  assign guard   = norm[3];
  assign rnd     = norm[2];
  assign stk     = |norm[1:0];
  assign inexact = guard | rnd | stk;
`ifdef FP_ADDSUB_RNE_EN
  assign round_up = guard & (rnd | stk | mant[0]);
`else
  assign round_up = 1'b0;
`endif
  // A rounding carry leaves the mantissa at zero, i.e. 1.0 at the next exponent.
  assign {mant_carry, mant_r} = {1'b0, mant} + (MAN_W+1)'(round_up);
  assign exp_r = exp_n + EW'(mant_carry);

  always_comb begin
    res_d   = '0;
    flags_d = '0;
    if (s2_q.is_nan) begin
      res_d = QNAN;
      flags_d[FLAG_INVALID] = 1'b1;
    end else if (s2_q.is_inf) begin
      res_d = {s2_q.inf_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (!norm[SW-1]) begin
      res_d = {s2_q.zero_sign, {(W-1){1'b0}}};
    end else if (exp_r[EW-1] || exp_r == '0) begin
      res_d = {s2_q.sign, {(W-1){1'b0}}};
      flags_d[FLAG_UNDERFLOW] = 1'b1;
      flags_d[FLAG_INEXACT]   = 1'b1;
    end else if (exp_r[EW-2:0] >= {1'b0, EXP_ONES}) begin
`ifdef FP_ADDSUB_RNE_EN
      res_d = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
`else
      res_d = {s2_q.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
      flags_d[FLAG_OVERFLOW] = 1'b1;
      flags_d[FLAG_INEXACT]  = 1'b1;
    end else begin
      res_d = {s2_q.sign, exp_r[EXP_W-1:0], mant_r};
      flags_d[FLAG_INEXACT] = inexact;
    end
  end

  // All stages advance together; a stalled output freezes the whole pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      result <= '0;
      flags  <= '0;
    end else if (in_ready) begin
      v1     <= in_valid;
      s1_q   <= s1_d;
      v2     <= v1;
      s2_q   <= s2_d;
      v3     <= v2;
      result <= res_d;
      flags  <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: randomized and directed bench for fp_addsub_pipe with an
// exact-integer reference model. Honours FP_ADDSUB_RNE_EN like the design.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  int          checks = 0;
  int          errors = 0;
  logic [35:0] exp_q[$];
  int          pops = 0;
  logic [31:0] last_res = '0;
  logic [3:0]  last_flags = '0;
  logic        last_in_ready = 1'b0;
  logic        accepted = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res = '0;
  logic [3:0]  prev_flags = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Exact reference: every finite operand becomes an integer multiple of the
  // smallest normal ulp, the exact sum is formed, then rounded to 24 bits.
  function automatic logic [35:0] ref_result(input logic [31:0] xo, input logic [31:0] yo, input logic s);
    logic         sx, sy, rs, nan_x, nan_y, inf_x, inf_y, inex;
    int           ex, ey, p, sh, e;
    logic [299:0] vx, vy, mag, kept, rem, half;
    sx = xo[31];
    sy = yo[31] ^ s;
    ex = int'(xo[30:23]);
    ey = int'(yo[30:23]);
    nan_x = (ex == 255) && (xo[22:0] != 0);
    nan_y = (ey == 255) && (yo[22:0] != 0);
    inf_x = (ex == 255) && (xo[22:0] == 0);
    inf_y = (ey == 255) && (yo[22:0] == 0);
    if (nan_x || nan_y || (inf_x && inf_y && sx != sy)) return {4'b1000, 32'h7FC00000};
    if (inf_x) return {4'b0000, sx, 8'hFF, 23'h0};
    if (inf_y) return {4'b0000, sy, 8'hFF, 23'h0};
    vx = (ex == 0) ? '0 : ({276'd0, 1'b1, xo[22:0]} << (ex - 1));
    vy = (ey == 0) ? '0 : ({276'd0, 1'b1, yo[22:0]} << (ey - 1));
    if (sx == sy) begin
      mag = vx + vy; rs = sx;
    end else if (vx >= vy) begin
      mag = vx - vy; rs = sx;
    end else begin
      mag = vy - vx; rs = sy;
    end
    if (mag == 0) return {4'b0000, (ex == 0 && ey == 0) ? (sx & sy) : 1'b0, 31'h0};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p < 23) return {4'b0011, rs, 31'h0};
    sh   = p - 23;
    kept = mag >> sh;
    rem  = mag - (kept << sh);
    inex = (rem != 0);
    e    = p - 22;
`ifdef FP_ADDSUB_RNE_EN
    if (sh > 0) begin
      half = 300'd1 << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 1;
    end
    if (kept == (300'd1 << 24)) begin
      kept = kept >> 1;
      e++;
    end
    if (e >= 255) return {4'b0101, rs, 8'hFF, 23'h0};
`else
    half = '0;
    if (e >= 255) return {4'b0101, rs, 8'hFE, 23'h7FFFFF};
`endif
    return {3'b000, inex, rs, 8'(e), kept[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int          r;
    logic [7:0]  e;
    logic [22:0] f;
    r = $urandom_range(0, 99);
    f = 23'($urandom);
    if (r < 5)       e = 8'd0;
    else if (r < 9)  begin e = 8'hFF; f = '0; end
    else if (r < 12) begin e = 8'hFF; f = f | 23'd1; end
    else if (r < 20) e = 8'($urandom_range(250, 254));
    else if (r < 28) e = 8'($urandom_range(1, 4));
    else             e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, f};
  endfunction

  // Second operand is often a near neighbour of the first to provoke cancellation.
  function automatic logic [31:0] rand_partner(input logic [31:0] xo);
    int e;
    if ($urandom_range(0, 9) < 4 && xo[30:23] > 8'd1 && xo[30:23] < 8'd254) begin
      e = int'(xo[30:23]) + int'($urandom_range(0, 2)) - 1;
      return {1'($urandom), 8'(e), xo[22:0] ^ 23'($urandom_range(0, 15))};
    end
    return rand_op();
  endfunction

  // One clock: drive after the edge, then sample and score the handshakes
  // that the next edge will complete.
  task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                      input logic isub, input logic ordy);
    logic [35:0] want;
    @(posedge clk);
    #1;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    sub       = isub;
    out_ready = ordy;
    #1;
    if (prev_stall) begin
      check_val("hold_valid", 64'(out_valid), 64'd1);
      check_val("hold_result", 64'({flags, result}), 64'({prev_flags, prev_res}));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        want = exp_q.pop_front();
        check_val("result", 64'({flags, result}), 64'(want));
        pops++;
        last_res   = result;
        last_flags = flags;
      end
    end
    prev_stall    = out_valid && !out_ready;
    prev_res      = result;
    prev_flags    = flags;
    last_in_ready = in_ready;
    accepted      = in_valid && in_ready;
    if (accepted) exp_q.push_back(ref_result(ia, ib, isub));
  endtask

  task automatic run_directed(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                              input logic isub, input logic [35:0] want);
    int start;
    int lat;
    start = pops;
    step(1'b1, ia, ib, isub, 1'b1);
    lat = 0;
    while (pops == start && lat < 10) begin
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      lat++;
    end
    check_val({tag, "_latency"}, 64'(lat), 64'd3);
    check_val(tag, 64'({last_flags, last_res}), 64'(want));
  endtask

  logic [31:0] op_a[8];
  logic [31:0] op_b[8];
  logic        op_s[8];

  initial begin
    int          idx;
    int          start;
    logic [31:0] ra;

    // Reset state
    #12;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_result", 64'(result), 64'd0);
    check_val("rst_flags", 64'(flags), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    run_directed("add_1_2",   32'h3F800000, 32'h40000000, 1'b0, {4'b0000, 32'h40400000});
    run_directed("cancel",    32'h3F800000, 32'h3F800000, 1'b1, {4'b0000, 32'h00000000});
`ifdef FP_ADDSUB_RNE_EN
    run_directed("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {4'b0101, 32'h7F800000});
`else
    run_directed("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {4'b0101, 32'h7F7FFFFF});
`endif
    run_directed("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, {4'b1000, 32'h7FC00000});
    run_directed("ninf_p_1",  32'hFF800000, 32'h3F800000, 1'b0, {4'b0000, 32'hFF800000});
    run_directed("nan_in",    32'h3F800000, 32'h7FA00001, 1'b0, {4'b1000, 32'h7FC00000});
    run_directed("subn_p_1",  32'h00000001, 32'h3F800000, 1'b0, {4'b0000, 32'h3F800000});
    run_directed("underflow", 32'h00800001, 32'h00800000, 1'b1, {4'b0011, 32'h00000000});
    run_directed("nzero",     32'h80000000, 32'h00000000, 1'b1, {4'b0000, 32'h80000000});
    run_directed("tie_even",  32'h3F800000, 32'h33800000, 1'b0, {4'b0001, 32'h3F800000});

    // Back-to-back burst with a three-cycle output stall
    for (int i = 0; i < 8; i++) begin
      op_a[i] = rand_op();
      op_b[i] = rand_partner(op_a[i]);
      op_s[i] = 1'($urandom);
    end
    idx   = 0;
    start = pops;
    for (int c = 0; c < 40 && (idx < 8 || pops < start + 8); c++) begin
      step(idx < 8, (idx < 8) ? op_a[idx] : 32'h0, (idx < 8) ? op_b[idx] : 32'h0,
           (idx < 8) ? op_s[idx] : 1'b0, !(c >= 4 && c <= 6));
      if (c >= 4 && c <= 6) check_val("b2b_in_ready_low", 64'(last_in_ready), 64'd0);
      if (c == 3 || c == 7) check_val("b2b_in_ready_high", 64'(last_in_ready), 64'd1);
      if (accepted) idx++;
    end
    check_val("b2b_count", 64'(pops - start), 64'd8);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      ra = rand_op();
      step(1'b1, ra, rand_partner(ra), 1'($urandom), 1'b1);
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_val("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_async_valid", 64'(out_valid), 64'd0);
    check_val("rst_async_result", 64'(result), 64'd0);
    check_val("rst_async_flags", 64'(flags), 64'd0);
    check_val("rst_async_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      check_val("stale_valid", 64'(out_valid), 64'd0);
    end

    // Randomized traffic with random backpressure
    for (int i = 0; i < 1500; i++) begin
      ra = rand_op();
      step($urandom_range(0, 9) < 8, ra, rand_partner(ra), 1'($urandom), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    end
    check_val("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
